// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants and types for the machine-mode trap sequencer.
//   IRQ_* : 2-bit trap type codes matching the CSRfile mcause decode.
//   trap_state_e : sequencer states (TS_IDLE, TS_ENTER, TS_RET, TS_FLUSH).
//   align_vec() : clears the two mode bits of an mtvec value.
package trap_ctrl_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IRQ_NONE  = 2'b00;
    localparam logic [1:0] IRQ_TIMER = 2'b01;
    localparam logic [1:0] IRQ_ECALL = 2'b10;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'b00,
        TS_ENTER = 2'b01,
        TS_RET   = 2'b10,
        TS_FLUSH = 2'b11
    } trap_state_e;

    // mtvec low bits hold the vectoring mode, not address bits
    function automatic logic [XLEN-1:0] align_vec(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage, CSRfile and fetch-redirect signals around trap_ctrl.
//   slave  : the trap sequencer (consumes commit/CSR inputs, drives trap outputs).
//   master : the surrounding pipeline / CSRfile side.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic            commitValid;
    logic [XLEN-1:0] pcW;
    logic [XLEN-1:0] npcW;
    logic            ecallW;
    logic            mretW;
    logic            itTime;
    logic [XLEN-1:0] irqAddr;
    logic [XLEN-1:0] mepc_i;
    logic [1:0]      IRQtype;
    logic            IRQret;
    logic [XLEN-1:0] retAddr;
    logic            redirectValid;
    logic [XLEN-1:0] redirectPC;
    logic            flush;
    logic            busy;

    modport slave (
        input  commitValid, pcW, npcW, ecallW, mretW, itTime, irqAddr, mepc_i,
        output IRQtype, IRQret, retAddr, redirectValid, redirectPC, flush, busy
    );

    modport master (
        output commitValid, pcW, npcW, ecallW, mretW, itTime, irqAddr, mepc_i,
        input  IRQtype, IRQret, retAddr, redirectValid, redirectPC, flush, busy
    );

endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry/return sequencer between commit, CSRfile and fetch.
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : trap_ctrl_if.slave (commit event inputs, CSR values, trap/redirect/flush outputs)
// Parameter FLUSH_CYCLES (1..15): flush cycles following the redirect cycle.
// Macro TRAP_TIMER_IRQ_EN: when defined, itTime raises timer interrupts at commit
// boundaries; when undefined, itTime is ignored and only ecall/mret are sequenced.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);

    trap_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      irq_type_q;
    logic [XLEN-1:0] ret_addr_q;
    logic            irq_ret_q;
    logic            redir_q;
    logic            flush_q;
    logic            busy_q;
    logic            timer_c;

    // Timer source, compiled out when the feature is disabled
`ifdef TRAP_TIMER_IRQ_EN
    assign timer_c = bus.itTime;
`else
    logic unused_timer_c;
    assign timer_c        = 1'b0;
    assign unused_timer_c = bus.itTime;
`endif

    // Sequencer: outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TS_IDLE;
            cnt_q      <= '0;
            irq_type_q <= IRQ_NONE;
            ret_addr_q <= '0;
            irq_ret_q  <= 1'b0;
            redir_q    <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            irq_type_q <= IRQ_NONE;
            irq_ret_q  <= 1'b0;
            redir_q    <= 1'b0;
            case (state_q)
                TS_IDLE: begin
                    // ecall > mret > timer; timer without a commit stays pending
                    if (bus.commitValid) begin
                        if (bus.ecallW) begin
                            ret_addr_q <= bus.pcW;
                            irq_type_q <= IRQ_ECALL;
                            redir_q    <= 1'b1;
                            flush_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= TS_ENTER;
                        end else if (bus.mretW) begin
                            irq_ret_q  <= 1'b1;
                            redir_q    <= 1'b1;
                            flush_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= TS_RET;
                        end else if (timer_c) begin
                            // committing instruction retires; resume after it
                            ret_addr_q <= bus.npcW;
                            irq_type_q <= IRQ_TIMER;
                            redir_q    <= 1'b1;
                            flush_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= TS_ENTER;
                        end
                    end
                end
                TS_ENTER, TS_RET: begin
                    cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                    state_q <= TS_FLUSH;
                end
                TS_FLUSH: begin
                    // commits here are killed instructions, not events
                    if (cnt_q == '0) begin
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= TS_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= TS_IDLE;
            endcase
        end
    end

    assign bus.IRQtype       = irq_type_q;
    assign bus.IRQret        = irq_ret_q;
    assign bus.retAddr       = ret_addr_q;
    assign bus.redirectValid = redir_q;
    assign bus.flush         = flush_q;
    assign bus.busy          = busy_q;

    // Only combinational input-to-output path: the CSR target addresses
    assign bus.redirectPC = (state_q == TS_ENTER) ? align_vec(bus.irqAddr) :
                            (state_q == TS_RET)   ? bus.mepc_i : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl (table vectors, hand sequences,
// randomized traffic against a schedule-based reference model).
module tb_trap_ctrl;

    localparam int unsigned FC = 3;
`ifdef TRAP_TIMER_IRQ_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if bus();

    trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected outputs for one cycle; src: 0 none, 1 mtvec, 2 mepc
    typedef struct {
        logic [1:0] irq_type;
        logic       irq_ret;
        logic       redir;
        int         src;
        logic       flush;
    } exp_t;

    typedef struct {
        logic        ecall;
        logic        mret;
        logic        tim;
        logic [63:0] pc;
        logic [63:0] npc;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic [1:0]  x_type;
        logic        x_ret;
        logic [63:0] x_ret_addr;
        logic [63:0] x_rpc;
        int          x_flush;
    } vec_t;

    exp_t        plan[$];
    bit          cur_idle;
    logic [63:0] m_ret;
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          dut_timer_pulses;
    int          mdl_timer_pulses;
    int          dut_type_pulses;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_commit();
        bus.commitValid = 1'b0;
        bus.ecallW      = 1'b0;
        bus.mretW       = 1'b0;
        bus.itTime      = 1'b0;
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e.irq_type = 2'b00;
        e.irq_ret  = 1'b0;
        e.redir    = 1'b0;
        e.src      = 0;
        e.flush    = 1'b0;
        return e;
    endfunction

    // Advance one clock: model reacts to the pre-edge inputs, DUT is checked after the edge
    task automatic step();
        exp_t e;
        logic [63:0] rpc;
        bit take_ecall, take_mret, take_tim;
        if (rst) begin
            plan.delete();
            m_ret = 64'd0;
        end else if (cur_idle && bus.commitValid) begin
            take_ecall = bus.ecallW;
            take_mret  = !bus.ecallW && bus.mretW;
            take_tim   = TIMER_EN && !bus.ecallW && !bus.mretW && bus.itTime;
            if (take_ecall || take_tim || take_mret) begin
                e = idle_rec();
                e.redir = 1'b1;
                e.flush = 1'b1;
                if (take_mret) begin
                    e.irq_ret = 1'b1;
                    e.src     = 2;
                end else begin
                    e.irq_type = take_ecall ? 2'b10 : 2'b01;
                    e.src      = 1;
                    m_ret      = take_ecall ? bus.pcW : bus.npcW;
                end
                plan.push_back(e);
                e = idle_rec();
                e.flush = 1'b1;
                for (int k = 0; k < int'(FC); k++) plan.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (plan.size() > 0) begin
            e = plan.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = idle_rec();
            cur_idle = 1'b1;
        end
        rpc = (e.src == 1) ? (bus.irqAddr & ~64'h3) : (e.src == 2) ? bus.mepc_i : 64'd0;
        chk("IRQtype",       64'(bus.IRQtype),       64'(e.irq_type));
        chk("IRQret",        64'(bus.IRQret),        64'(e.irq_ret));
        chk("retAddr",       bus.retAddr,            m_ret);
        chk("redirectValid", 64'(bus.redirectValid), 64'(e.redir));
        chk("redirectPC",    bus.redirectPC,         rpc);
        chk("flush",         64'(bus.flush),         64'(e.flush));
        chk("busy",          64'(bus.busy),          64'(e.flush));
        if (bus.IRQtype == 2'b01) dut_timer_pulses++;
        if (e.irq_type == 2'b01) mdl_timer_pulses++;
        if (bus.IRQtype != 2'b00) dut_type_pulses++;
    endtask

    task automatic do_reset();
        clear_commit();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nfl;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        cur_idle = 1'b1;
        m_ret    = 64'd0;
        rst      = 1'b1;
        clear_commit();
        bus.pcW     = 64'd0;
        bus.npcW    = 64'd0;
        bus.irqAddr = 64'd0;
        bus.mepc_i  = 64'd0;

        // Directed single-event vectors
        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h8000_0100, 64'h8000_0104, 64'h8000_0800, 64'h0,
                    2'b10, 1'b0, 64'h8000_0100, 64'h8000_0800, 1 + FC};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h8000_0200, 64'h8000_0204, 64'h8000_0803, 64'h0,
                    TIMER_EN ? 2'b01 : 2'b00, 1'b0,
                    TIMER_EN ? 64'h8000_0204 : 64'h0,
                    TIMER_EN ? 64'h8000_0800 : 64'h0,
                    TIMER_EN ? 1 + FC : 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 64'h8000_0300, 64'h8000_0304, 64'h8000_0800, 64'h8000_0104,
                    2'b00, 1'b1, 64'h0, 64'h8000_0104, 1 + FC};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h8000_1000, 64'h8000_1004, 64'h8000_0400, 64'h0,
                    2'b10, 1'b0, 64'h8000_1000, 64'h8000_0400, 1 + FC};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 64'h8000_2000, 64'h8000_2004, 64'h8000_0C01, 64'h8000_0500,
                    2'b10, 1'b0, 64'h8000_2000, 64'h8000_0C00, 1 + FC};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 64'h8000_3000, 64'h8000_3004, 64'h8000_0800, 64'h8000_3004,
                    2'b00, 1'b1, 64'h0, 64'h8000_3004, 1 + FC};

        do_reset();
        chk("reset_busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            step();
            bus.commitValid = 1'b1;
            bus.ecallW  = vecs[i].ecall;
            bus.mretW   = vecs[i].mret;
            bus.itTime  = vecs[i].tim;
            bus.pcW     = vecs[i].pc;
            bus.npcW    = vecs[i].npc;
            bus.irqAddr = vecs[i].mtvec;
            bus.mepc_i  = vecs[i].mepc;
            step();
            chk($sformatf("vec%0d_IRQtype", i), 64'(bus.IRQtype), 64'(vecs[i].x_type));
            chk($sformatf("vec%0d_IRQret", i), 64'(bus.IRQret), 64'(vecs[i].x_ret));
            chk($sformatf("vec%0d_retAddr", i), bus.retAddr, vecs[i].x_ret_addr);
            chk($sformatf("vec%0d_redirectPC", i), bus.redirectPC, vecs[i].x_rpc);
            nfl = bus.flush ? 1 : 0;
            clear_commit();
            for (int k = 0; k < int'(FC) + 1; k++) begin
                step();
                if (bus.flush) nfl++;
            end
            chk($sformatf("vec%0d_flush_len", i), 64'(nfl), 64'(vecs[i].x_flush));
            chk($sformatf("vec%0d_busy_end", i), 64'(bus.busy), 64'd0);
        end

        // Timer pending without commits, then taken at the next commit
        do_reset();
        bus.irqAddr = 64'h8000_0800;
        bus.itTime  = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("tim_pending_busy", 64'(bus.busy), 64'd0);
        bus.commitValid = 1'b1;
        bus.npcW        = 64'h8000_0204;
        step();
        chk("tim_taken_type", 64'(bus.IRQtype), TIMER_EN ? 64'd1 : 64'd0);
        clear_commit();
        for (int k = 0; k < int'(FC) + 1; k++) step();

        // Events during FLUSH are ignored
        do_reset();
        dut_type_pulses = 0;
        bus.commitValid = 1'b1;
        bus.ecallW      = 1'b1;
        bus.pcW         = 64'h8000_0400;
        step();
        bus.itTime = 1'b1;
        for (int k = 0; k < int'(FC); k++) step();
        clear_commit();
        step();
        chk("flush_mask_pulses", 64'(dut_type_pulses), 64'd1);

        // Reset in the second FLUSH cycle, then normal entry
        do_reset();
        bus.commitValid = 1'b1;
        bus.ecallW      = 1'b1;
        bus.pcW         = 64'h8000_0500;
        step();
        clear_commit();
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_flush", {bus.retAddr[61:0], bus.IRQtype}, 64'd0);
        chk("rst_mid_flags", 64'({bus.IRQret, bus.redirectValid, bus.flush, bus.busy}), 64'd0);
        rst = 1'b0;
        bus.commitValid = 1'b1;
        bus.ecallW      = 1'b1;
        bus.pcW         = 64'h8000_0600;
        step();
        chk("post_rst_entry", 64'(bus.IRQtype), 64'd2);
        clear_commit();
        for (int k = 0; k < int'(FC) + 1; k++) step();

        // itTime held across 20 commits
        do_reset();
        dut_timer_pulses = 0;
        mdl_timer_pulses = 0;
        bus.itTime = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.commitValid = 1'b1;
            bus.npcW        = 64'h8000_7000 + 64'(k * 4);
            step();
        end
        clear_commit();
        for (int k = 0; k < int'(FC) + 1; k++) step();
        chk("timer_pulse_count", 64'(dut_timer_pulses), 64'(mdl_timer_pulses));

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rst             = ($urandom_range(99) == 0);
            bus.commitValid = ($urandom_range(1) == 1);
            bus.ecallW      = ($urandom_range(9) == 0);
            bus.mretW       = ($urandom_range(9) == 0);
            bus.itTime      = ($urandom_range(2) == 0);
            bus.pcW         = {$urandom, $urandom};
            bus.npcW        = {$urandom, $urandom};
            bus.irqAddr     = {$urandom, $urandom};
            bus.mepc_i      = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequences machine-mode trap entry and return around `CSRfile`. It watches the commit stage for `ecall` and `mret`, and the timer-pending line `itTime`, then picks the precise commit boundary for each event. It drives `IRQtype`/`IRQret`/`retAddr` into `CSRfile`, redirects fetch to `irqAddr` or `mepc_o`, and holds a pipeline flush for a fixed number of cycles. It sits between the writeback/commit stage, `CSRfile` and the fetch PC mux.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 3: cycles `flush` stays high after the redirect cycle; legal range 1–15.

Ports (reset is synchronous, active-high; one clock):
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `commitValid` in 1: an instruction commits this cycle.
- `pcW` in 64: PC of the committing instruction.
- `npcW` in 64: architectural next PC of the committing instruction.
- `ecallW` in 1: the committing instruction is `ecall`.
- `mretW` in 1: the committing instruction is `mret`.
- `itTime` in 1: timer interrupt pending and enabled, from `CSRfile`.
- `irqAddr` in 64: `mtvec` value, from `CSRfile`.
- `mepc_i` in 64: `mepc` value, from `CSRfile`.
- `IRQtype` out 2: `2'b01` timer interrupt, `2'b10` ecall, `2'b00` none.
- `IRQret` out 1: `mret` pulse to `CSRfile`.
- `retAddr` out 64: value `CSRfile` writes into `mepc`.
- `redirectValid` out 1: fetch PC override.
- `redirectPC` out 64: new fetch PC.
- `flush` out 1: kill all in-flight instructions in IF..MEM.
- `busy` out 1: state is not IDLE.

## Operation
FSM states: IDLE, ENTER, RET, FLUSH.
- **IDLE.** Events are evaluated only when `commitValid=1`, in this priority order:
  - `ecallW`: capture `retAddr<=pcW` and `type<=2'b10`; go to ENTER.
  - `mretW`: go to RET.
  - else `itTime`: capture `retAddr<=npcW` and `type<=2'b01`; go to ENTER. The committing instruction completes and the interrupt is taken after it.
  - If `ecallW` and `mretW` are both set, ecall wins (this is illegal decode, but the behaviour is defined).
  - With `commitValid=0`, `itTime` is held pending and is not latched. It is taken at the next commit.
- **ENTER** (1 cycle):
  - `IRQtype=type`.
  - `redirectValid=1`, `redirectPC=irqAddr & ~64'h3`.
  - `flush=1`.
  - Next state is FLUSH; load the counter with `FLUSH_CYCLES-1`.
- **RET** (1 cycle):
  - `IRQret=1`.
  - `redirectValid=1`, `redirectPC=mepc_i`.
  - `flush=1`.
  - Next state is FLUSH; load the counter with `FLUSH_CYCLES-1`.
- **FLUSH:**
  - `flush=1`.
  - Decrement the counter each cycle; go to IDLE when it reaches 0.
  - `commitValid`, `ecallW`, `mretW` and `itTime` are all ignored. Commits in this state are not lost events: they are killed instructions.
- **Outputs:** all outputs are decoded from the registered state and the captured `type`/`retAddr` (Moore). No input-to-output combinational path exists except `irqAddr`/`mepc_i` to `redirectPC`.
- **Reset:**
  - `rst=1` in any state forces IDLE at the next edge and clears the counter, `type` and `retAddr`.
  - While in reset, all outputs are 0.
  - A reset asserted mid-ENTER/FLUSH abandons the sequence; no partial `IRQtype` pulse follows.

## Timing
- Commit with an event at edge N. ENTER or RET is visible in cycle N+1, and `CSRfile` updates `mepc`/`mcause`/`mstatus` at edge N+2.
- `IRQtype` and `IRQret` are exactly 1-cycle pulses. `redirectValid` is 1 cycle and coincides with them.
- `flush` is high for `1+FLUSH_CYCLES` consecutive cycles.
- `busy` is high for the same cycles as `flush`.
- Back-to-back events: earliest re-evaluation is the first IDLE cycle. An interrupt pending after `mret` is taken at the first commit after the flush ends.
- Latency from an event commit to the next possible event: `2+FLUSH_CYCLES` cycles.

## Configuration
- `TRAP_TIMER_IRQ_EN` defined: timer interrupts behave as described above.
- `TRAP_TIMER_IRQ_EN` undefined: `itTime` is ignored, `IRQtype` never equals `2'b01`, and only `ecall` and `mret` are sequenced.

## Structure
- `defines.v` gets these constants:
  - `IRQ_NONE`, `IRQ_TIMER`, `IRQ_ECALL` (2-bit codes matching `CSRfile`'s `mcause` decode).
  - The 2-bit state encodings `TS_IDLE`, `TS_ENTER`, `TS_RET`, `TS_FLUSH`.
- Single module, no sub-module. The flush counter is 4 bits, inline.

## Test plan
- **Ecall at commit:** `commitValid=1`, `ecallW=1`, `pcW=0x80000100`, `irqAddr=0x80000800` → next cycle `IRQtype=2'b10`, `retAddr=0x80000100`, `redirectPC=0x80000800`. Then `flush` high for 4 cycles (`FLUSH_CYCLES=3`), then `busy=0`.
- **Timer interrupt:** `itTime=1` held with `commitValid=0` for 5 cycles → no action. Then a commit with `npcW=0x80000204` → `IRQtype=2'b01`, `retAddr=0x80000204`.
- **Mret:** `mretW=1` at commit with `mepc_i=0x80000104` → `IRQret=1` for 1 cycle, `redirectPC=0x80000104`, `IRQtype=0`.
- **Priority and masking:** `ecallW=1` and `itTime=1` on the same commit → ecall taken. `itTime` and `ecallW` asserted during FLUSH → ignored, no second pulse.
- **Reset mid-operation:** `rst=1` in the second FLUSH cycle → all outputs 0 next cycle, state IDLE. A commit with `ecallW` right after reset → normal entry.
- **Config off:** build without `TRAP_TIMER_IRQ_EN`, hold `itTime=1` across 20 commits → `IRQtype` stays `2'b00` throughout.
